// File: rtl/ag6502_bus_pkg.sv
// Shared types and constants for the ag6502 bus sequencer: phase encoding,
// data-bus idle value and counter sizing.
package ag6502_bus_pkg;

  typedef enum logic [1:0] {
    PH_P1 = 2'd0,
    PH_G1 = 2'd1,
    PH_P2 = 2'd2,
    PH_G2 = 2'd3
  } phase_t;

  // Idle bus value: cpu_din after reset and the fill value for an aborted read.
  localparam logic [7:0] DIN_RST = 8'hFF;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ag6502_phase_gen.sv
// Non-overlapping phi_0/phi_1/phi_2 generator: P1 -> G1 -> P2 -> G2, one state per phase.
// P1 is held while hold is high on its last cycle; P2 stretches while stretch_req stays high.
module ag6502_phase_gen
  import ag6502_bus_pkg::*;
#(
  parameter int HALF_LO = 5,
  parameter int HALF_HI = 5,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stretch_req,
  input  logic hold,
  output logic phi_0,
  output logic phi_1,
  output logic phi_2,
  output logic cyc_done,
  output logic capture,
  output logic tmo_edge
);

  localparam int CW = cnt_width(HALF_LO, HALF_HI, TIMEOUT);
  localparam logic [CW-1:0] LO_LAST  = CW'(HALF_LO - 1);
  localparam logic [CW-1:0] HI_LAST  = CW'(HALF_HI - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 2);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  phase_t        state;
  logic [CW-1:0] cnt;
  logic          p2_end;

  assign capture  = (state == PH_P1) && (cnt == LO_LAST) && !hold;
  // The G1 cycle is request edge 1, so P2 count c closes on request edge c+2.
  assign tmo_edge = (state == PH_P2) && (cnt == TMO_LAST);
  assign p2_end   = (state == PH_P2) && (cnt >= HI_LAST) && !stretch_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PH_P1;
      cnt      <= '0;
      phi_0    <= 1'b0;
      phi_1    <= 1'b1;
      phi_2    <= 1'b0;
      cyc_done <= 1'b0;
    end else begin
      cyc_done <= 1'b0;
      case (state)
        PH_P1: begin
          if (capture) begin
            state                 <= PH_G1;
            cnt                   <= '0;
            {phi_0, phi_1, phi_2} <= 3'b100;
          end else if (cnt != LO_LAST) begin
            cnt <= cnt + 1'b1;
          end
        end
        PH_G1: begin
          state                 <= PH_P2;
          {phi_0, phi_1, phi_2} <= 3'b101;
        end
        PH_P2: begin
          if (p2_end) begin
            state                 <= PH_G2;
            cnt                   <= '0;
            {phi_0, phi_1, phi_2} <= 3'b000;
            cyc_done              <= 1'b1;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state                 <= PH_P1;
          cnt                   <= '0;
          {phi_0, phi_1, phi_2} <= 3'b010;
        end
      endcase
    end
  end

endmodule

// File: rtl/ag6502_bus_seq.sv
// ag6502 cycle sequencer: captures each core bus cycle at the end of P1 and runs it over
// req/ack; slow memory stretches phi_2 high, bounded by TIMEOUT with an 8'hFF read fill.
module ag6502_bus_seq
  import ag6502_bus_pkg::*;
#(
  parameter int HALF_LO = 5,
  parameter int HALF_HI = 5,
  parameter int TIMEOUT = 255
) (
  input  logic        baseclk,
  input  logic        rst,
  output logic        phi_0,
  output logic        phi_1,
  output logic        phi_2,
  input  logic [15:0] cpu_ab,
  input  logic        cpu_read,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  input  logic        halt,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        cyc_done,
  output logic        bus_timeout
);

  logic capture;
  logic tmo_edge;

  ag6502_phase_gen #(
    .HALF_LO(HALF_LO),
    .HALF_HI(HALF_HI),
    .TIMEOUT(TIMEOUT)
  ) u_phase (
    .clk        (baseclk),
    .rst_n      (rst),
    .stretch_req(mem_req),
    .hold       (halt),
    .phi_0      (phi_0),
    .phi_1      (phi_1),
    .phi_2      (phi_2),
    .cyc_done   (cyc_done),
    .capture    (capture),
    .tmo_edge   (tmo_edge)
  );

  always_ff @(posedge baseclk or negedge rst) begin
    if (!rst) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_din     <= DIN_RST;
      bus_timeout <= 1'b0;
    end else begin
      bus_timeout <= 1'b0;
      if (capture) begin
        mem_req   <= 1'b1;
        mem_we    <= !cpu_read;
        mem_addr  <= cpu_ab;
        mem_wdata <= cpu_dout;
      end else if (mem_req && mem_ack) begin
        mem_req <= 1'b0;
        if (!mem_we) cpu_din <= mem_rdata;
      end else if (mem_req && tmo_edge) begin
        // An ack on the timeout edge itself still wins above.
        mem_req     <= 1'b0;
        bus_timeout <= 1'b1;
        if (!mem_we) cpu_din <= DIN_RST;
      end
    end
  end

endmodule

// File: tb/tb_ag6502_bus_seq.sv
// Bench for ag6502_bus_seq: two instances (TIMEOUT 255 and 16) with a delayed-ack memory,
// each core cycle checked against phase lengths and bus results computed from the timing rules.
module tb_ag6502_bus_seq;

  localparam int HALF_LO = 5;
  localparam int HALF_HI = 5;
  localparam int TMO_A   = 255;
  localparam int TMO_B   = 16;
  localparam int BOUND   = 600;

  logic baseclk = 1'b0;
  logic rst     = 1'b1;
  always #5 baseclk = ~baseclk;

  logic [15:0] cpu_ab    = '0;
  logic        cpu_read  = 1'b1;
  logic [7:0]  cpu_dout  = '0;
  logic        halt      = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic        comb_ack  = 1'b0;
  logic        stray_ack = 1'b0;
  int          ack_d     = 1000;
  logic        sel       = 1'b0;

  logic        phi_0_a, phi_1_a, phi_2_a, mem_req_a, mem_we_a, mem_ack_a, cyc_done_a, bus_timeout_a;
  logic [7:0]  cpu_din_a, mem_wdata_a;
  logic [15:0] mem_addr_a;
  logic        phi_0_b, phi_1_b, phi_2_b, mem_req_b, mem_we_b, mem_ack_b, cyc_done_b, bus_timeout_b;
  logic [7:0]  cpu_din_b, mem_wdata_b;
  logic [15:0] mem_addr_b;

  ag6502_bus_seq #(.HALF_LO(HALF_LO), .HALF_HI(HALF_HI), .TIMEOUT(TMO_A)) dut_a (
    .baseclk(baseclk), .rst(rst), .phi_0(phi_0_a), .phi_1(phi_1_a), .phi_2(phi_2_a),
    .cpu_ab(cpu_ab), .cpu_read(cpu_read), .cpu_dout(cpu_dout), .cpu_din(cpu_din_a),
    .halt(halt), .mem_req(mem_req_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata), .mem_ack(mem_ack_a),
    .cyc_done(cyc_done_a), .bus_timeout(bus_timeout_a));

  ag6502_bus_seq #(.HALF_LO(HALF_LO), .HALF_HI(HALF_HI), .TIMEOUT(TMO_B)) dut_b (
    .baseclk(baseclk), .rst(rst), .phi_0(phi_0_b), .phi_1(phi_1_b), .phi_2(phi_2_b),
    .cpu_ab(cpu_ab), .cpu_read(cpu_read), .cpu_dout(cpu_dout), .cpu_din(cpu_din_b),
    .halt(halt), .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata), .mem_ack(mem_ack_b),
    .cyc_done(cyc_done_b), .bus_timeout(bus_timeout_b));

  // Memory: ack is sampled on the ack_d-th rising edge after the request rises.
  int       age_a = 0, age_b = 0;
  logic [1:0] ack_q = '0;
  always @(negedge baseclk) begin
    age_a    <= mem_req_a ? age_a + 1 : 0;
    age_b    <= mem_req_b ? age_b + 1 : 0;
    ack_q[0] <= mem_req_a && (age_a + 1 == ack_d);
    ack_q[1] <= mem_req_b && (age_b + 1 == ack_d);
  end
  assign mem_ack_a = comb_ack ? mem_req_a : (ack_q[0] | stray_ack);
  assign mem_ack_b = comb_ack ? mem_req_b : (ack_q[1] | stray_ack);

  int overlap = 0, cyc_cnt_a = 0;
  always @(negedge baseclk) begin
    if ((phi_1_a & phi_2_a) | (phi_1_b & phi_2_b)) overlap <= overlap + 1;
    if (cyc_done_a) cyc_cnt_a <= cyc_cnt_a + 1;
  end

  logic [2:0]  o_phi;
  logic        o_req, o_we, o_cyc, o_tmo;
  logic [15:0] o_addr;
  logic [7:0]  o_wdata, o_din;
  always_comb begin
    o_phi   = sel ? {phi_0_b, phi_1_b, phi_2_b} : {phi_0_a, phi_1_a, phi_2_a};
    o_req   = sel ? mem_req_b : mem_req_a;
    o_we    = sel ? mem_we_b : mem_we_a;
    o_addr  = sel ? mem_addr_b : mem_addr_a;
    o_wdata = sel ? mem_wdata_b : mem_wdata_a;
    o_din   = sel ? cpu_din_b : cpu_din_a;
    o_cyc   = sel ? cyc_done_b : cyc_done_a;
    o_tmo   = sel ? bus_timeout_b : bus_timeout_a;
  end

  int n_chk = 0, n_fail = 0, n_ack = 0, n_tmo = 0;
  bit hung = 1'b0;
  logic [7:0] exp_din [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge baseclk);
    #1;
  endtask

  function automatic int p2_model(input int d, input int lim);
    int k;
    k = (d > lim) ? lim : d;
    return (k > HALF_HI) ? k : HALF_HI;
  endfunction

  task automatic check_reset();
    check("rst_phi", 32'(o_phi), 32'(3'b010));
    check("rst_req", 32'(o_req), 32'(0));
    check("rst_we", 32'(o_we), 32'(0));
    check("rst_addr", 32'(o_addr), 32'(0));
    check("rst_wdata", 32'(o_wdata), 32'(0));
    check("rst_din", 32'(o_din), 32'(8'hFF));
    check("rst_cyc_done", 32'(o_cyc), 32'(0));
    check("rst_bus_timeout", 32'(o_tmo), 32'(0));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check_reset();
    repeat (3) @(posedge baseclk);
    #1;
    check("rst_held_phi", 32'(o_phi), 32'(3'b010));
    rst = 1'b1;
    exp_din[0] = 8'hFF;
    exp_din[1] = 8'hFF;
  endtask

  // Runs one core cycle from the first P1 sample through G2 and compares it with the model.
  task automatic run_cycle(input bit read, input int d, input logic [15:0] ab,
                           input logic [7:0] dout, input logic [7:0] rd,
                           input int halt_n, input bit stray);
    int p1, p2, req_len, tmo, p1_req, unstable, lim, k;
    logic [7:0] din_end;
    lim = sel ? TMO_B : TMO_A;
    k   = (d > lim) ? lim : d;
    cpu_ab = ab; cpu_read = read; cpu_dout = dout; mem_rdata = rd; ack_d = d;
    p1 = 0; p2 = 0; req_len = 0; tmo = 0; p1_req = 0; unstable = 0; din_end = o_din;
    while (o_phi == 3'b010 && p1 < BOUND) begin
      p1++;
      if (o_req) p1_req++;
      stray_ack = stray && (p1 <= 2);
      halt = (p1 >= HALF_LO) && (p1 < HALF_LO + halt_n);
      step();
    end
    halt = 1'b0; stray_ack = 1'b0;
    check("p1_len", 32'(p1), 32'(HALF_LO + halt_n));
    check("p1_no_req", 32'(p1_req), 32'(0));
    check("g1_phase", 32'(o_phi), 32'(3'b100));
    check("g1_req", 32'(o_req), 32'(1));
    check("mem_addr", 32'(o_addr), 32'(ab));
    check("mem_we", 32'(o_we), 32'(!read));
    if (!read) check("mem_wdata", 32'(o_wdata), 32'(dout));
    if (o_req) req_len++;
    step();
    while (o_phi == 3'b101 && p2 < BOUND) begin
      p2++;
      if (o_req) begin
        req_len++;
        if (o_addr != ab || o_we != !read || (!read && o_wdata != dout)) unstable++;
      end
      if (o_tmo) tmo++;
      din_end = o_din;
      step();
    end
    if (read) exp_din[sel] = (d > lim) ? 8'hFF : rd;
    check("p2_len", 32'(p2), 32'(p2_model(d, lim)));
    check("period", 32'(p1 + p2 + 2), 32'(HALF_LO + halt_n + p2_model(d, lim) + 2));
    check("req_len", 32'(req_len), 32'(k));
    check("timeout_pulses", 32'(tmo), 32'(d > lim));
    check("req_stable", 32'(unstable), 32'(0));
    check("din_at_sample", 32'(din_end), 32'(exp_din[sel]));
    check("g2_phase", 32'(o_phi), 32'(3'b000));
    check("g2_cyc_done", 32'(o_cyc), 32'(1));
    if (p1 >= BOUND || p2 >= BOUND) hung = 1'b1;
    if (d > lim) n_tmo++; else n_ack++;
    step();
  endtask

  initial begin
    step();
    sel = 1'b0;
    do_reset();

    comb_ack = 1'b1;
    run_cycle(1'b1, 1, 16'h0200, 8'h00, 8'hA9, 0, 1'b0);
    comb_ack = 1'b0;
    run_cycle(1'b0, 7, 16'hC0F0, 8'h5A, 8'h11, 0, 1'b0);
    run_cycle(1'b1, 2, 16'h0300, 8'h00, 8'h42, 20, 1'b0);

    // Abandon a write mid-P2, then check a stray ack after reset is not taken.
    cpu_ab = 16'h1234; cpu_read = 1'b0; cpu_dout = 8'h77; ack_d = 1000;
    for (int i = 0; i < BOUND && o_phi != 3'b101; i++) step();
    repeat (3) step();
    check("pre_rst_req", 32'(o_req), 32'(1));
    #2;
    do_reset();
    run_cycle(1'b0, 4, 16'h4000, 8'h99, 8'h66, 0, 1'b1);

    sel = 1'b1;
    do_reset();
    comb_ack = 1'b1;
    run_cycle(1'b1, 1, 16'h8000, 8'h00, 8'h3C, 0, 1'b0);
    comb_ack = 1'b0;
    run_cycle(1'b1, 1000, 16'h8001, 8'h00, 8'h55, 0, 1'b0);
    comb_ack = 1'b1;
    run_cycle(1'b1, 1, 16'h8002, 8'h00, 8'hC3, 0, 1'b0);
    comb_ack = 1'b0;

    sel = 1'b0;
    do_reset();
    n_ack = 0; n_tmo = 0;
    begin
      int cyc0;
      cyc0 = cyc_cnt_a;
      for (int i = 0; i < 70 && !hung; i++)
        run_cycle(1'($urandom), int'($urandom_range(1, 300)), 16'($urandom),
                  8'($urandom), 8'($urandom), 0, 1'b0);
      check("cyc_done_count", 32'(cyc_cnt_a - cyc0), 32'(n_ack + n_tmo));
    end
    check("phi1_phi2_overlap", 32'(overlap), 32'(0));
    check("no_hang", 32'(hung), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
